// File: rtl/async_rx_param.sv
// Oversampling asynchronous serial receiver with optional parity, one or two stop bits,
// a held output frame with ready/acknowledge handshake, and overrun/framing/parity flags.
module async_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RXD,
  input  logic                 DATA_ACK,
  output logic [DATA_BITS-1:0] Frame,
  output logic                 RX_BUSY,
  output logic                 RX_READY,
  output logic                 RX_ERROR,
  output logic                 RX_PERR,
  output logic                 RX_OVR
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("async_rx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("async_rx_param: OVERSAMPLE must be even and 4..32");
  end
  if (PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_framing
    $error("async_rx_param: PARITY must be 0..2 and STOP_BITS 1..2");
  end

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = 4;
  localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);
  localparam logic OddParity = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  logic [1:0]           sync_q;
  logic                 rxs;
  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 ferr_q, perr_q, armed_q;
  logic [DATA_BITS-1:0] frame_q;
  logic                 ready_q, ferr_out_q, perr_out_q, ovr_q;
  logic                 done, ferr_fin;

  assign rxs = sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  // done marks the last stop-bit sample; outputs update on that same edge.
  always_comb begin
    done     = (state_q == StStop) && (cnt_q == FullM1) && (idx_q == LastStop);
    ferr_fin = ferr_q | ~rxs;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      armed_q    <= 1'b0;
      frame_q    <= '0;
      ready_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (rxs) armed_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (!rxs && armed_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfM1) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            state_q <= rxs ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
            if (idx_q == LastData) begin
              idx_q   <= '0;
              state_q <= (PARITY != 0) ? StPar : StStop;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPar: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            perr_q  <= (^shreg_q) ^ rxs ^ OddParity;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == FullM1) begin
            cnt_q  <= '0;
            ferr_q <= ferr_fin;
            if (idx_q == LastStop) begin
              idx_q   <= '0;
              state_q <= StIdle;
              // A line still low at the final stop sample is a break: wait for it to clear.
              if (!rxs) armed_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (done) begin
        if (!ready_q || DATA_ACK) begin
          frame_q    <= shreg_q;
          ferr_out_q <= ferr_fin;
          perr_out_q <= perr_q;
          ready_q    <= 1'b1;
          ovr_q      <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (DATA_ACK && ready_q) begin
        ready_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign Frame    = frame_q;
  assign RX_BUSY  = (state_q != StIdle);
  assign RX_READY = ready_q;
  assign RX_ERROR = ferr_out_q;
  assign RX_PERR  = perr_out_q;
  assign RX_OVR   = ovr_q;

endmodule

// File: tb/tb_async_rx_param.sv
// Scoreboard bench for async_rx_param: four configurations share a clock and reset,
// stimulus pushes expected frames, a monitor pops them whenever RX_READY rises.
module tb_async_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] rxd, ack, busy, rdy, ferr, perr, ovr;
  logic [7:0] fr0, fr1, fr2;
  logic [8:0] fr3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic        ferr;
    logic        perr;
  } exp_t;
  exp_t sb[$];

  async_rx_param u0 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd[0]), .DATA_ACK(ack[0]), .Frame(fr0),
    .RX_BUSY(busy[0]), .RX_READY(rdy[0]), .RX_ERROR(ferr[0]), .RX_PERR(perr[0]), .RX_OVR(ovr[0])
  );
  async_rx_param #(.PARITY(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd[1]), .DATA_ACK(ack[1]), .Frame(fr1),
    .RX_BUSY(busy[1]), .RX_READY(rdy[1]), .RX_ERROR(ferr[1]), .RX_PERR(perr[1]), .RX_OVR(ovr[1])
  );
  async_rx_param #(.STOP_BITS(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd[2]), .DATA_ACK(ack[2]), .Frame(fr2),
    .RX_BUSY(busy[2]), .RX_READY(rdy[2]), .RX_ERROR(ferr[2]), .RX_PERR(perr[2]), .RX_OVR(ovr[2])
  );
  async_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16)) u3 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd[3]), .DATA_ACK(ack[3]), .Frame(fr3),
    .RX_BUSY(busy[3]), .RX_READY(rdy[3]), .RX_ERROR(ferr[3]), .RX_PERR(perr[3]), .RX_OVR(ovr[3])
  );

  function automatic logic [15:0] frame_of(input int i);
    case (i)
      0:       return {8'h00, fr0};
      1:       return {8'h00, fr1};
      2:       return {8'h00, fr2};
      default: return {7'h00, fr3};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int i, input logic [15:0] f, input logic fe, input logic pe);
    exp_t e;
    e.inst  = i;
    e.frame = f;
    e.ferr  = fe;
    e.perr  = pe;
    sb.push_back(e);
  endtask

  task automatic send_bits(input int i, input logic [31:0] bits, input int n, input int os);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxd[i] = bits[k];
      repeat (os - 1) @(negedge clk);
    end
  endtask

  // np: parity bit present, ns: stop-bit count, st[0] is the first stop bit on the line.
  task automatic send_frame(input int i, input logic [15:0] d, input int nb, input int os,
                            input int np, input logic pb, input int ns, input logic [1:0] st);
    logic [31:0] v;
    int p;
    v = '0;
    p = 1;
    for (int k = 0; k < nb; k++) begin
      v[p] = d[k];
      p++;
    end
    if (np != 0) begin
      v[p] = pb;
      p++;
    end
    for (int k = 0; k < ns; k++) begin
      v[p] = st[k];
      p++;
    end
    send_bits(i, v, p, os);
  endtask

  task automatic wait_ready(input int i, input int budget);
    int n;
    n = 0;
    while (!rdy[i] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("ready_wait_u%0d", i), {31'h0, rdy[i]}, 32'h1);
  endtask

  task automatic ack_frame(input int i);
    @(negedge clk);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
    check($sformatf("ack_clears_ready_u%0d", i), {31'h0, rdy[i]}, 32'h0);
    check($sformatf("ack_clears_ovr_u%0d", i), {31'h0, ovr[i]}, 32'h0);
  endtask

  // Monitor: every rising RX_READY must match the oldest expected frame.
  initial begin
    logic [3:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] && !prev[i]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame u%0d: got frame %0h with no frame expected",
                     i, frame_of(i));
          end else begin
            e = sb.pop_front();
            if (e.inst != i || frame_of(i) !== e.frame || ferr[i] !== e.ferr ||
                perr[i] !== e.perr) begin
              errors++;
              $display("FAIL frame_u%0d: got inst %0d frame %0h err %0b perr %0b expected inst %0d frame %0h err %0b perr %0b",
                       i, i, frame_of(i), ferr[i], perr[i], e.inst, e.frame, e.ferr, e.perr);
            end
          end
        end
      end
      prev = rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst_n = 1'b0;
    rxd   = '1;
    ack   = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {12'h0, busy, rdy, ferr, perr, ovr}, 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_frame_u%0d", i), {16'h0, frame_of(i)}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 on defaults, with exact ready latency relative to the stop bit.
    expect_frame(0, 16'h00A5, 1'b0, 1'b0);
    send_bits(0, {22'h0, 9'hA5, 1'b0}, 9, 8);
    @(negedge clk);
    rxd[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("ready_before_stop_sample", {31'h0, rdy[0]}, 32'h0);
    @(posedge clk);
    #1;
    check("ready_after_stop_sample", {31'h0, rdy[0]}, 32'h1);
    check("busy_drops_after_stop", {31'h0, busy[0]}, 32'h0);
    repeat (2) @(negedge clk);
    ack_frame(0);

    // Start-bit glitch of OVERSAMPLE/2-1 cycles.
    saw = 1'b0;
    @(negedge clk);
    rxd[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (busy[0]) saw = 1'b1;
      if (c == 2) rxd[0] = 1'b1;
    end
    check("glitch_busy_pulse", {31'h0, saw}, 32'h1);
    check("glitch_no_flags", {27'h0, busy[0], rdy[0], ferr[0], perr[0], ovr[0]}, 32'h0);

    // Even parity: 0x03 has even weight, so parity bit 1 is an error and 0 is not.
    expect_frame(1, 16'h0003, 1'b0, 1'b1);
    send_frame(1, 16'h0003, 8, 8, 1, 1'b1, 1, 2'b01);
    wait_ready(1, 40);
    ack_frame(1);
    expect_frame(1, 16'h0003, 1'b0, 1'b0);
    send_frame(1, 16'h0003, 8, 8, 1, 1'b0, 1, 2'b01);
    wait_ready(1, 40);
    ack_frame(1);

    // Two stop bits: second one low is a framing error, both high is clean.
    expect_frame(2, 16'h005A, 1'b1, 1'b0);
    send_frame(2, 16'h005A, 8, 8, 0, 1'b0, 2, 2'b01);
    rxd[2] = 1'b1;
    wait_ready(2, 40);
    ack_frame(2);
    expect_frame(2, 16'h00C3, 1'b0, 1'b0);
    send_frame(2, 16'h00C3, 8, 8, 0, 1'b0, 2, 2'b11);
    wait_ready(2, 40);
    ack_frame(2);

    // Overrun: second frame lost while the first is held.
    expect_frame(0, 16'h0011, 1'b0, 1'b0);
    send_frame(0, 16'h0011, 8, 8, 0, 1'b0, 1, 2'b01);
    send_frame(0, 16'h0022, 8, 8, 0, 1'b0, 1, 2'b01);
    repeat (4) @(negedge clk);
    check("overrun_frame_kept", {16'h0, frame_of(0)}, 32'h11);
    check("overrun_flag", {30'h0, rdy[0], ovr[0]}, 32'h3);
    ack_frame(0);

    // Break: line held low through the stop sample and beyond.
    expect_frame(0, 16'h0000, 1'b1, 1'b0);
    send_frame(0, 16'h0000, 8, 8, 0, 1'b0, 1, 2'b00);
    repeat (16) @(negedge clk);
    check("break_not_rearmed", {31'h0, busy[0]}, 32'h0);
    rxd[0] = 1'b1;
    wait_ready(0, 40);
    ack_frame(0);

    // 9-bit / 16x: reset during data bit 4 of 0x1F0, then a clean 0x0AB.
    send_bits(3, 32'h0, 5, 16);
    @(negedge clk);
    rxd[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_mid_frame", {31'h0, busy[3]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_flags", {27'h0, busy[3], rdy[3], ferr[3], perr[3], ovr[3]}, 32'h0);
    check("midframe_reset_frame", {16'h0, frame_of(3)}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("no_frame_after_reset", {30'h0, busy[3], rdy[3]}, 32'h0);
    expect_frame(3, 16'h00AB, 1'b0, 1'b0);
    send_frame(3, 16'h00AB, 9, 16, 0, 1'b0, 1, 2'b01);
    wait_ready(3, 60);
    ack_frame(3);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_rx_param.md
ASYNC_RX_PARAM -- requirements
Module: async_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 8, CLK cycles per bit (even, legal 4..32).
REQ-003 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-005 SHALL have port CLK  input  1  single clock, running at OVERSAMPLE x baud rate.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RXD  input  1  serial line, asynchronous, idle high, LSB first.
REQ-008 SHALL have port DATA_ACK  input  1  consumer acknowledge of held frame.
REQ-009 SHALL have port Frame  output  DATA_BITS  last accepted data word.
REQ-010 SHALL have port RX_BUSY  output  1  frame reception in progress.
REQ-011 SHALL have port RX_READY  output  1  Frame valid, held until acknowledged.
REQ-012 SHALL have port RX_ERROR  output  1  framing error on held frame (a stop bit sampled 0).
REQ-013 SHALL have port RX_PERR  output  1  parity error on held frame (always 0 when PARITY=0).
REQ-014 SHALL have port RX_OVR  output  1  overrun: a frame was lost while RX_READY was high.

Function
REQ-015 SHALL pass RXD through a 2-flop synchroniser reset to 1; all logic uses the synchronised value (rxs).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP with a bit-tick counter (0..OVERSAMPLE-1) and bit index counter.
REQ-017 IDLE: on first cycle rxs=0 (cycle t0) -> START, counter cleared; RX_BUSY high from t0+1.
REQ-018 START: at t0+OVERSAMPLE/2 sample rxs; 1 -> glitch, return IDLE, no flags changed; 0 -> DATA.
REQ-019 DATA: data bit i (i=0..DATA_BITS-1) sampled at t0+OVERSAMPLE/2+(i+1)*OVERSAMPLE, shifted LSB first.
REQ-020 PAR (only if PARITY!=0): one bit sampled one OVERSAMPLE period after last data bit; error if XOR(data,parity bit) is 1 for even or 0 for odd.
REQ-021 STOP: STOP_BITS samples at successive OVERSAMPLE periods; any 0 sample sets framing error for this frame.
REQ-022 After the last stop sample, FSM SHALL return to IDLE next cycle and drop RX_BUSY (no wait for end of stop bit).
REQ-023 Frame completion (cycle after last stop sample) with RX_READY low: Frame, RX_ERROR, RX_PERR loaded; RX_READY set; frames with errors are still delivered.
REQ-024 Frame completion with RX_READY high and no DATA_ACK that cycle: Frame/RX_ERROR/RX_PERR unchanged, RX_OVR set.
REQ-025 DATA_ACK sampled high while RX_READY high SHALL clear RX_READY and RX_OVR next cycle; DATA_ACK with RX_READY low has no effect.
REQ-026 DATA_ACK coincident with frame completion: new frame loaded, RX_READY stays 1, RX_OVR cleared, no overrun.
REQ-027 A frame with rxs=0 through the whole stop sample (break) SHALL be reported as framing error; FSM re-arms only after rxs returns 1.
REQ-028 Parameter values outside legal ranges SHALL cause an elaboration-time error.

Reset
REQ-029 RST_N low SHALL immediately force FSM to IDLE, counters to 0, synchroniser to 1, Frame=0, RX_BUSY=0, RX_READY=0, RX_ERROR=0, RX_PERR=0, RX_OVR=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release the receiver waits for a new falling edge on rxs.

Verification
REQ-031 Defaults, send 0xA5, 1 stop -> Frame=0xA5, RX_READY=1 one cycle after stop sample, RX_ERROR=RX_PERR=0.
REQ-032 Low pulse of OVERSAMPLE/2-1 cycles on idle RXD -> RX_BUSY pulses, RX_READY stays 0, no flags.
REQ-033 PARITY=1, send 0x03 with parity bit 1 -> Frame=0x03, RX_PERR=1; with parity bit 0 -> RX_PERR=0.
REQ-034 STOP_BITS=2, send 0x5A with second stop bit 0 -> Frame=0x5A, RX_ERROR=1.
REQ-035 Send 0x11 then 0x22 without DATA_ACK -> Frame=0x11, RX_OVR=1; DATA_ACK -> RX_READY=0, RX_OVR=0.
REQ-036 DATA_BITS=9, OVERSAMPLE=16, send 0x1F0, assert RST_N low at data bit 4 then release -> all outputs 0; next frame 0x0AB received correctly.
